clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- User-side controller for the alarm-clock core; it is the writer of the core's load interface.
- Turns debounced push-button levels into BCD H_in/M_in digits and one-cycle LD_time/LD_alarm strobes.
- Owns alarm enable (AL_ON) and alarm stop (AL_STOP), and auto-stops a ringing alarm.
- Runs on the core's 1 s clock, so all strobes are sampled by the core on the next clk_1s edge.

Parameters:
TIMEOUT, 30, idle cycles in an edit state before aborting without load
RING_MAX, 60, cycles Alarm may stay high before automatic AL_STOP
SNOOZE_MIN, 5, minutes added on snooze (1..59; used only with CLKSET_SNOOZE_EN)

Ports:
clk_1s  in  1  1 s clock
reset  in  1  asynchronous, active-high reset
btn_set_time  in  1  level; rising edge enters time edit
btn_set_alarm  in  1  level; rising edge enters alarm edit
btn_inc  in  1  level; rising edge increments current field (snooze while ringing)
btn_next  in  1  level; rising edge advances field or commits (stop while ringing)
btn_al_en  in  1  level; rising edge toggles AL_ON
Alarm  in  1  ringing indication from clock core
cur_h1  in  2  current hour tens (BCD)
cur_h0  in  4  current hour units
cur_m1  in  4  current minute tens
cur_m0  in  4  current minute units
H_in1  out  2  hour tens to core
H_in0  out  4  hour units to core
M_in1  out  4  minute tens to core
M_in0  out  4  minute units to core
LD_time  out  1  one-cycle time-load strobe
LD_alarm  out  1  one-cycle alarm-load strobe
AL_ON  out  1  alarm enable
AL_STOP  out  1  one-cycle alarm-stop strobe
edit_active  out  1  high in SET_HOUR/SET_MIN
edit_field  out  1  0 = hour, 1 = minute

Behaviour:
- Interface: reset is asynchronous, active-high; the clock is clk_1s.
- Reset values:
  - All outputs 0.
  - State IDLE; edit target = time.
  - Alarm shadow = 00:00; counters 0; button history registers 0.
- Edge detect:
  - A press is the cycle where the button is 1 and its previous sample was 0.
  - Action happens on that same edge; holding a button produces no repeats.
- States: IDLE, SET_HOUR, SET_MIN, COMMIT, SNOOZE_LD (macro only).
- IDLE, Alarm=0:
  - set_time press: load digits from cur_*, target = time, go to SET_HOUR.
  - set_alarm press: load digits from alarm shadow, target = alarm, go to SET_HOUR.
  - Both pressed in the same cycle: time wins.
- IDLE, Alarm=1:
  - Set buttons are ignored.
  - next press: AL_STOP = 1 for one cycle.
  - Ring counter increments each cycle Alarm=1 and clears when Alarm=0.
  - Counter reaching RING_MAX-1: AL_STOP pulse, counter clears.
  - Manual and auto stop in the same cycle produce a single pulse.
- SET_HOUR:
  - inc press: BCD increment 23→00; h0==9 → h1+1, h0=0; otherwise h0+1.
  - next press: go to SET_MIN.
  - inc and next in the same cycle: next wins, inc is dropped.
- SET_MIN:
  - inc press: 59→00 with no carry into the hour; m0==9 → m1+1, m0=0.
  - next press: go to COMMIT.
- COMMIT (one cycle):
  - Assert LD_time or LD_alarm per target.
  - Alarm target also updates the shadow.
  - Return to IDLE.
- Digit outputs:
  - H_in*/M_in* are the edit registers directly.
  - They are stable from edit entry through COMMIT and held afterwards.
- Timeout:
  - Idle counter clears on any press; it increments in SET_HOUR/SET_MIN.
  - Reaching TIMEOUT-1: go to IDLE with no load strobe; shadow is unchanged.
- btn_al_en toggles AL_ON in any state.
- Reset mid-edit: IDLE, no strobe emitted.
- LD_time and LD_alarm are never high together.
- AL_STOP and LD_* may coincide only on snooze.

Optional Feature:
- Macro CLKSET_SNOOZE_EN.
- Defined:
  - In IDLE with Alarm=1, an inc press gives an AL_STOP pulse and enters SNOOZE_LD.
  - SNOOZE_LD: digits = cur time + SNOOZE_MIN minutes, minute overflow carries into the hour, 23:xx wraps to 00.
  - SNOOZE_LD asserts LD_alarm for one cycle, updates the shadow, and returns to IDLE.
  - AL_ON is unchanged.
- Undefined: inc is ignored while ringing; SNOOZE_LD does not exist.

Decomposition:
- Shared package clock_pkg:
  - state enum.
  - HOUR_MAX=23 and MIN_MAX=59 constants.
  - BCD digit width constants.
- Sub-module bcd_time_add (combinational):
  - Inputs: BCD hh:mm and an increment.
  - Modes: hour-only, minute-only no-carry, and minute-with-carry.
  - Used for both the edit increments and snooze.

Test Plan:
- cur=15:30, set_time press, inc ×2, next, inc ×3, next → LD_time one cycle with H=17, M=33; AL_ON remains 0.
- set_alarm press from shadow 00:00, inc ×23 then inc → hour wraps 23→00; next, M inc ×60 → 00; next → LD_alarm with 00:00.
- set_time press, no buttons for TIMEOUT cycles → back in IDLE, no LD_* ever asserted, edit_active drops.
- Alarm held 1, no buttons → AL_STOP single pulse after RING_MAX cycles; next press at cycle 3 → AL_STOP at that edge, ring counter cleared.
- Macro on: cur=23:58, Alarm=1, inc press → AL_STOP and next-cycle LD_alarm with 00:03; macro off → no strobes.
- Reset asserted during SET_MIN → all outputs 0 immediately; set_time and set_alarm pressed together → time target.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the alarm-clock user-side controller.
//   state_t     : controller FSM states (ST_SNOOZE_LD only exists when the
//                 CLKSET_SNOOZE_EN macro is defined)
//   target_t    : which core register a finished edit is loaded into
//   add_mode_t  : operating mode of the bcd_time_add helper
//   tensOf/unitsOf : split a small binary value (< 100) into BCD digits
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int H1_W     = 2;
    localparam int DIGIT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_COMMIT
`ifdef CLKSET_SNOOZE_EN
        , ST_SNOOZE_LD
`endif
    } state_t;

    typedef enum logic {
        TGT_TIME  = 1'b0,
        TGT_ALARM = 1'b1
    } target_t;

    typedef enum logic [1:0] {
        ADD_HOUR,
        ADD_MIN,
        ADD_MIN_CARRY
    } add_mode_t;

    function automatic logic [DIGIT_W-1:0] tensOf(input logic [6:0] v);
        return DIGIT_W'(v / 7'd10);
    endfunction

    function automatic logic [DIGIT_W-1:0] unitsOf(input logic [6:0] v);
        return DIGIT_W'(v % 7'd10);
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// ---------------------------------------------------------------------------
// bcd_time_add
// Combinational BCD hh:mm adder shared by the field editor and snooze.
//   h1_i/h0_i/m1_i/m0_i : BCD time operand
//   incr_i              : amount to add (minutes, or hours in ADD_HOUR)
//   mode_i              : ADD_HOUR      - hour only, 23 wraps to 00
//                         ADD_MIN       - minute only, 59 wraps to 00, no carry
//                         ADD_MIN_CARRY - minutes with carry into the hour
//   h1_o/h0_o/m1_o/m0_o : BCD result
// The operand is assumed to be a legal time and the increment to cause at
// most one wrap of the affected field.
// ---------------------------------------------------------------------------
module bcd_time_add
    import clock_pkg::*;
(
    input  logic [H1_W-1:0]    h1_i,
    input  logic [DIGIT_W-1:0] h0_i,
    input  logic [DIGIT_W-1:0] m1_i,
    input  logic [DIGIT_W-1:0] m0_i,
    input  logic [5:0]         incr_i,
    input  add_mode_t          mode_i,
    output logic [H1_W-1:0]    h1_o,
    output logic [DIGIT_W-1:0] h0_o,
    output logic [DIGIT_W-1:0] m1_o,
    output logic [DIGIT_W-1:0] m0_o
);

    logic [6:0] hBin;
    logic [6:0] mBin;
    logic [6:0] incr;
    logic [6:0] hSum;
    logic [6:0] mSum;

    // Work in binary: convert, add, wrap, convert back to BCD.
    always_comb begin
        hBin = 7'(h1_i) * 7'd10 + 7'(h0_i);
        mBin = 7'(m1_i) * 7'd10 + 7'(m0_i);
        incr = 7'(incr_i);
        hSum = hBin;
        mSum = mBin;
        case (mode_i)
            ADD_HOUR: begin
                hSum = hBin + incr;
                if (hSum > 7'(HOUR_MAX)) hSum = hSum - 7'(HOUR_MAX + 1);
            end
            ADD_MIN: begin
                mSum = mBin + incr;
                if (mSum > 7'(MIN_MAX)) mSum = mSum - 7'(MIN_MAX + 1);
            end
            ADD_MIN_CARRY: begin
                mSum = mBin + incr;
                if (mSum > 7'(MIN_MAX)) begin
                    mSum = mSum - 7'(MIN_MAX + 1);
                    hSum = hBin + 7'd1;
                    if (hSum > 7'(HOUR_MAX)) hSum = 7'd0;
                end
            end
            default: ;
        endcase
    end

    assign h1_o = H1_W'(tensOf(hSum));
    assign h0_o = unitsOf(hSum);
    assign m1_o = tensOf(mSum);
    assign m0_o = unitsOf(mSum);

endmodule

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// User-side writer of the alarm-clock core load interface. Debounced button
// levels are edge-detected and drive an edit FSM that produces BCD digits
// plus one-cycle LD_time / LD_alarm strobes; it also owns AL_ON and AL_STOP
// and auto-stops an alarm that rings for too long.
// Optional feature: define CLKSET_SNOOZE_EN to make an inc press while
// ringing stop the alarm and re-arm it SNOOZE_MIN minutes from now.
// Ports:
//   clk_1s, reset        : 1 s clock, asynchronous active-high reset
//   btn_*                : debounced button levels (rising edge = press)
//   Alarm                : ringing indication from the core
//   cur_h1..cur_m0       : current time from the core (BCD)
//   H_in1..M_in0         : digits presented to the core
//   LD_time, LD_alarm    : one-cycle load strobes
//   AL_ON, AL_STOP       : alarm enable level, one-cycle stop strobe
//   edit_active          : high in SET_HOUR / SET_MIN
//   edit_field           : 0 = hour, 1 = minute
// ---------------------------------------------------------------------------
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT    = 30,
    parameter int RING_MAX   = 60,
    parameter int SNOOZE_MIN = 5
)(
    input  logic               clk_1s,
    input  logic               reset,
    input  logic               btn_set_time,
    input  logic               btn_set_alarm,
    input  logic               btn_inc,
    input  logic               btn_next,
    input  logic               btn_al_en,
    input  logic               Alarm,
    input  logic [H1_W-1:0]    cur_h1,
    input  logic [DIGIT_W-1:0] cur_h0,
    input  logic [DIGIT_W-1:0] cur_m1,
    input  logic [DIGIT_W-1:0] cur_m0,
    output logic [H1_W-1:0]    H_in1,
    output logic [DIGIT_W-1:0] H_in0,
    output logic [DIGIT_W-1:0] M_in1,
    output logic [DIGIT_W-1:0] M_in0,
    output logic               LD_time,
    output logic               LD_alarm,
    output logic               AL_ON,
    output logic               AL_STOP,
    output logic               edit_active,
    output logic               edit_field
);

    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam int RING_W = $clog2(RING_MAX);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MAX - 1);

    state_t  state_q, state_d;
    target_t target_q, target_d;

    logic [4:0] btn_q;
    logic [4:0] btnNow;
    logic [4:0] press;
    logic       pressSetTime, pressSetAlarm, pressInc, pressNext, pressAlEn;
    logic       anyPress;

    logic [H1_W-1:0]    h1_q, h1_d, sh1_q, sh1_d;
    logic [DIGIT_W-1:0] h0_q, h0_d, sh0_q, sh0_d;
    logic [DIGIT_W-1:0] m1_q, m1_d, sm1_q, sm1_d;
    logic [DIGIT_W-1:0] m0_q, m0_d, sm0_q, sm0_d;

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic              alOn_q, alOn_d;
    logic              alStop_q, alStop_d;

    logic [H1_W-1:0]    addH1, sumH1;
    logic [DIGIT_W-1:0] addH0, addM1, addM0, sumH0, sumM1, sumM0;
    logic [5:0]         addIncr;
    add_mode_t          addMode;

    assign btnNow        = {btn_al_en, btn_next, btn_inc, btn_set_alarm, btn_set_time};
    assign press         = btnNow & ~btn_q;
    assign pressSetTime  = press[0];
    assign pressSetAlarm = press[1];
    assign pressInc      = press[2];
    assign pressNext     = press[3];
    assign pressAlEn     = press[4];
    assign anyPress      = |press;

    // In IDLE the adder is pre-set for snooze (current time + SNOOZE_MIN with
    // carry); in the edit states it steps the active field by one.
    always_comb begin
        addH1   = h1_q;
        addH0   = h0_q;
        addM1   = m1_q;
        addM0   = m0_q;
        addIncr = 6'd1;
        addMode = ADD_HOUR;
        case (state_q)
            ST_IDLE: begin
                addH1   = cur_h1;
                addH0   = cur_h0;
                addM1   = cur_m1;
                addM0   = cur_m0;
                addIncr = 6'(SNOOZE_MIN);
                addMode = ADD_MIN_CARRY;
            end
            ST_SET_MIN: addMode = ADD_MIN;
            default: ;
        endcase
    end

    bcd_time_add u_add (
        .h1_i   (addH1),
        .h0_i   (addH0),
        .m1_i   (addM1),
        .m0_i   (addM0),
        .incr_i (addIncr),
        .mode_i (addMode),
        .h1_o   (sumH1),
        .h0_o   (sumH0),
        .m1_o   (sumM1),
        .m0_o   (sumM0)
    );

    // State register and all controller storage.
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= TGT_TIME;
            btn_q    <= '0;
            h1_q     <= '0;
            h0_q     <= '0;
            m1_q     <= '0;
            m0_q     <= '0;
            sh1_q    <= '0;
            sh0_q    <= '0;
            sm1_q    <= '0;
            sm0_q    <= '0;
            idle_q   <= '0;
            ring_q   <= '0;
            alOn_q   <= 1'b0;
            alStop_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            btn_q    <= btnNow;
            h1_q     <= h1_d;
            h0_q     <= h0_d;
            m1_q     <= m1_d;
            m0_q     <= m0_d;
            sh1_q    <= sh1_d;
            sh0_q    <= sh0_d;
            sm1_q    <= sm1_d;
            sm0_q    <= sm0_d;
            idle_q   <= idle_d;
            ring_q   <= ring_d;
            alOn_q   <= alOn_d;
            alStop_q <= alStop_d;
        end
    end

    // Next-state logic. Idle and ring counters default to clear, so they only
    // run in the states that explicitly advance them.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        h1_d     = h1_q;
        h0_d     = h0_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        sh1_d    = sh1_q;
        sh0_d    = sh0_q;
        sm1_d    = sm1_q;
        sm0_d    = sm0_q;
        idle_d   = '0;
        ring_d   = '0;
        alOn_d   = alOn_q ^ pressAlEn;
        alStop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Alarm) begin
                    // Auto and manual stop in the same cycle fold into one pulse.
                    if (ring_q == RING_LAST) alStop_d = 1'b1;
                    else                     ring_d   = ring_q + RING_W'(1);
                    if (pressNext) begin
                        alStop_d = 1'b1;
                        ring_d   = '0;
                    end
`ifdef CLKSET_SNOOZE_EN
                    else if (pressInc) begin
                        alStop_d = 1'b1;
                        ring_d   = '0;
                        h1_d     = sumH1;
                        h0_d     = sumH0;
                        m1_d     = sumM1;
                        m0_d     = sumM0;
                        state_d  = ST_SNOOZE_LD;
                    end
`endif
                end else if (pressSetTime) begin
                    h1_d     = cur_h1;
                    h0_d     = cur_h0;
                    m1_d     = cur_m1;
                    m0_d     = cur_m0;
                    target_d = TGT_TIME;
                    state_d  = ST_SET_HOUR;
                end else if (pressSetAlarm) begin
                    h1_d     = sh1_q;
                    h0_d     = sh0_q;
                    m1_d     = sm1_q;
                    m0_d     = sm0_q;
                    target_d = TGT_ALARM;
                    state_d  = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                if (anyPress) begin
                    if (pressNext) state_d = ST_SET_MIN;
                    else if (pressInc) begin
                        h1_d = sumH1;
                        h0_d = sumH0;
                    end
                end else if (idle_q == IDLE_LAST) state_d = ST_IDLE;
                else idle_d = idle_q + IDLE_W'(1);
            end
            ST_SET_MIN: begin
                if (anyPress) begin
                    if (pressNext) state_d = ST_COMMIT;
                    else if (pressInc) begin
                        m1_d = sumM1;
                        m0_d = sumM0;
                    end
                end else if (idle_q == IDLE_LAST) state_d = ST_IDLE;
                else idle_d = idle_q + IDLE_W'(1);
            end
            ST_COMMIT: begin
                if (target_q == TGT_ALARM) begin
                    sh1_d = h1_q;
                    sh0_d = h0_q;
                    sm1_d = m1_q;
                    sm0_d = m0_q;
                end
                state_d = ST_IDLE;
            end
`ifdef CLKSET_SNOOZE_EN
            ST_SNOOZE_LD: begin
                sh1_d   = h1_q;
                sh0_d   = h0_q;
                sm1_d   = m1_q;
                sm0_d   = m0_q;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Load strobes decode straight from the one-cycle load states.
    always_comb begin
        LD_time  = (state_q == ST_COMMIT) && (target_q == TGT_TIME);
        LD_alarm = (state_q == ST_COMMIT) && (target_q == TGT_ALARM);
`ifdef CLKSET_SNOOZE_EN
        if (state_q == ST_SNOOZE_LD) LD_alarm = 1'b1;
`endif
    end

    assign H_in1       = h1_q;
    assign H_in0       = h0_q;
    assign M_in1       = m1_q;
    assign M_in0       = m0_q;
    assign AL_ON       = alOn_q;
    assign AL_STOP     = alStop_q;
    assign edit_active = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    assign edit_field  = (state_q == ST_SET_MIN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl. Expected strobes (cycle stamp, strobe
// set, load digits) are queued when the causing stimulus is issued; a
// monitor pops and compares whenever LD_time, LD_alarm or AL_STOP is high.
// Level outputs are compared directly after each stimulus step.
// ---------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int TB_TIMEOUT    = 30;
    localparam int TB_RING_MAX   = 60;
    localparam int TB_SNOOZE_MIN = 5;

    localparam logic [4:0] B_TIME  = 5'b00001;
    localparam logic [4:0] B_ALARM = 5'b00010;
    localparam logic [4:0] B_INC   = 5'b00100;
    localparam logic [4:0] B_NEXT  = 5'b01000;
    localparam logic [4:0] B_ALEN  = 5'b10000;

    logic       clk_1s = 1'b0;
    logic       reset  = 1'b1;
    logic [4:0] btn    = '0;
    logic       Alarm  = 1'b0;
    logic [1:0] cur_h1 = 2'd1;
    logic [3:0] cur_h0 = 4'd5;
    logic [3:0] cur_m1 = 4'd3;
    logic [3:0] cur_m0 = 4'd0;

    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, AL_ON, AL_STOP, edit_active, edit_field;

    typedef struct {
        int         cycle;
        logic [2:0] strobes;
        logic       chkDigits;
        logic [13:0] digits;
    } exp_t;

    exp_t expQ[$];
    int   vecCount  = 0;
    int   missCount = 0;
    int   cycleCnt  = 0;

    always #5 clk_1s = ~clk_1s;

    clock_set_ctrl #(
        .TIMEOUT    (TB_TIMEOUT),
        .RING_MAX   (TB_RING_MAX),
        .SNOOZE_MIN (TB_SNOOZE_MIN)
    ) dut (
        .clk_1s        (clk_1s),
        .reset         (reset),
        .btn_set_time  (btn[0]),
        .btn_set_alarm (btn[1]),
        .btn_inc       (btn[2]),
        .btn_next      (btn[3]),
        .btn_al_en     (btn[4]),
        .Alarm         (Alarm),
        .cur_h1        (cur_h1),
        .cur_h0        (cur_h0),
        .cur_m1        (cur_m1),
        .cur_m0        (cur_m0),
        .H_in1         (H_in1),
        .H_in0         (H_in0),
        .M_in1         (M_in1),
        .M_in0         (M_in0),
        .LD_time       (LD_time),
        .LD_alarm      (LD_alarm),
        .AL_ON         (AL_ON),
        .AL_STOP       (AL_STOP),
        .edit_active   (edit_active),
        .edit_field    (edit_field)
    );

    function automatic logic [13:0] bcd14(input int h, input int m);
        logic [13:0] r;
        r = {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge: drives the buttons for 'hold' cycles, releases
    // them and lets one more edge sample the release. The press edge is
    // cycleCnt+1 at the time of the call.
    task automatic applyStimulus(input logic [4:0] btns, input int hold);
        btn = btns;
        repeat (hold) @(negedge clk_1s);
        btn = '0;
        @(negedge clk_1s);
    endtask

    task automatic pushExp(input int cyc, input logic [2:0] strobes,
                           input logic chk, input logic [13:0] digits);
        exp_t e;
        e.cycle     = cyc;
        e.strobes   = strobes;
        e.chkDigits = chk;
        e.digits    = digits;
        expQ.push_back(e);
    endtask

    function automatic logic [13:0] dutDigits();
        return {H_in1, H_in0, M_in1, M_in0};
    endfunction

    // Monitor: every strobe the DUT presents must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1s);
            cycleCnt++;
            #1;
            if (LD_time || LD_alarm || AL_STOP) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", {29'd0, LD_time, LD_alarm, AL_STOP}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("strobe_cycle", cycleCnt, e.cycle);
                    checkOutput("strobe_set", {29'd0, LD_time, LD_alarm, AL_STOP}, {29'd0, e.strobes});
                    if (e.chkDigits) checkOutput("load_digits", {18'd0, dutDigits()}, {18'd0, e.digits});
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk_1s);
        checkOutput("reset_outputs",
            {12'd0, H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, AL_STOP, edit_active, edit_field},
            32'd0);
        reset = 1'b0;
        @(negedge clk_1s);

        // Time edit from 15:30: hour +2, minute +3, commit 17:33.
        applyStimulus(B_TIME, 1);
        checkOutput("time_entry_active", {31'd0, edit_active}, 32'd1);
        checkOutput("time_entry_field", {31'd0, edit_field}, 32'd0);
        checkOutput("time_entry_digits", {18'd0, dutDigits()}, {18'd0, bcd14(15, 30)});
        repeat (2) applyStimulus(B_INC, 1);
        checkOutput("hour_inc_x2", {18'd0, dutDigits()}, {18'd0, bcd14(17, 30)});
        applyStimulus(B_NEXT, 1);
        checkOutput("min_field", {31'd0, edit_field}, 32'd1);
        repeat (3) applyStimulus(B_INC, 1);
        checkOutput("min_inc_x3", {18'd0, dutDigits()}, {18'd0, bcd14(17, 33)});
        pushExp(cycleCnt + 1, 3'b100, 1'b1, bcd14(17, 33));
        applyStimulus(B_NEXT, 1);
        checkOutput("after_commit_active", {31'd0, edit_active}, 32'd0);
        checkOutput("al_on_untouched", {31'd0, AL_ON}, 32'd0);
        checkOutput("digits_held", {18'd0, dutDigits()}, {18'd0, bcd14(17, 33)});

        // Alarm edit from shadow 00:00 with hour and minute wraps.
        applyStimulus(B_ALARM, 1);
        checkOutput("alarm_entry_digits", {18'd0, dutDigits()}, {18'd0, bcd14(0, 0)});
        repeat (23) applyStimulus(B_INC, 1);
        checkOutput("hour_23", {18'd0, dutDigits()}, {18'd0, bcd14(23, 0)});
        applyStimulus(B_INC, 1);
        checkOutput("hour_wrap", {18'd0, dutDigits()}, {18'd0, bcd14(0, 0)});
        applyStimulus(B_NEXT, 1);
        repeat (59) applyStimulus(B_INC, 1);
        checkOutput("min_59", {18'd0, dutDigits()}, {18'd0, bcd14(0, 59)});
        applyStimulus(B_INC, 1);
        checkOutput("min_wrap_no_carry", {18'd0, dutDigits()}, {18'd0, bcd14(0, 0)});
        pushExp(cycleCnt + 1, 3'b010, 1'b1, bcd14(0, 0));
        applyStimulus(B_NEXT, 1);

        // Timeout: still editing after TIMEOUT-1 idle edges, idle after TIMEOUT.
        applyStimulus(B_TIME, 1);
        repeat (TB_TIMEOUT - 2) @(negedge clk_1s);
        checkOutput("timeout_minus1_active", {31'd0, edit_active}, 32'd1);
        @(negedge clk_1s);
        checkOutput("timeout_active_drop", {31'd0, edit_active}, 32'd0);

        // Auto-stop after RING_MAX ringing cycles.
        Alarm = 1'b1;
        pushExp(cycleCnt + TB_RING_MAX, 3'b001, 1'b0, 14'd0);
        repeat (TB_RING_MAX + 1) @(negedge clk_1s);
        Alarm = 1'b0;
        @(negedge clk_1s);
        checkOutput("ring_queue_drained", expQ.size(), 32'd0);

        // Manual stop on the third ringing cycle clears the ring counter.
        Alarm = 1'b1;
        repeat (2) @(negedge clk_1s);
        pushExp(cycleCnt + 1, 3'b001, 1'b0, 14'd0);
        pushExp(cycleCnt + 1 + TB_RING_MAX, 3'b001, 1'b0, 14'd0);
        applyStimulus(B_NEXT, 1);
        repeat (TB_RING_MAX) @(negedge clk_1s);
        Alarm = 1'b0;
        @(negedge clk_1s);
        checkOutput("manual_queue_drained", expQ.size(), 32'd0);

        // Snooze (or ignored inc) while ringing at 23:58.
        cur_h1 = 2'd2; cur_h0 = 4'd3; cur_m1 = 4'd5; cur_m0 = 4'd8;
        Alarm  = 1'b1;
`ifdef CLKSET_SNOOZE_EN
        pushExp(cycleCnt + 1, 3'b011, 1'b1, bcd14(0, 3));
`endif
        applyStimulus(B_INC, 1);
        Alarm = 1'b0;
        @(negedge clk_1s);
        checkOutput("snooze_al_on", {31'd0, AL_ON}, 32'd0);
        checkOutput("snooze_idle", {31'd0, edit_active}, 32'd0);
        applyStimulus(B_ALARM, 1);
`ifdef CLKSET_SNOOZE_EN
        checkOutput("shadow_after_snooze", {18'd0, dutDigits()}, {18'd0, bcd14(0, 3)});
`else
        checkOutput("shadow_after_snooze", {18'd0, dutDigits()}, {18'd0, bcd14(0, 0)});
`endif
        applyStimulus(B_ALEN, 1);
        checkOutput("al_en_toggle", {31'd0, AL_ON}, 32'd1);
        applyStimulus(B_NEXT, 1);
        checkOutput("in_set_min", {31'd0, edit_field}, 32'd1);

        // Asynchronous reset in SET_MIN clears everything without an edge.
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
            {12'd0, H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, AL_STOP, edit_active, edit_field},
            32'd0);
        repeat (2) @(negedge clk_1s);
        reset = 1'b0;
        @(negedge clk_1s);

        // Both set buttons together: time target wins; held inc counts once.
        cur_h1 = 2'd1; cur_h0 = 4'd5; cur_m1 = 4'd3; cur_m0 = 4'd0;
        applyStimulus(B_TIME | B_ALARM, 1);
        checkOutput("both_set_digits", {18'd0, dutDigits()}, {18'd0, bcd14(15, 30)});
        applyStimulus(B_INC, 3);
        checkOutput("held_inc_once", {18'd0, dutDigits()}, {18'd0, bcd14(16, 30)});
        applyStimulus(B_NEXT, 1);
        pushExp(cycleCnt + 1, 3'b100, 1'b1, bcd14(16, 30));
        applyStimulus(B_NEXT, 1);

        repeat (3) @(negedge clk_1s);
        checkOutput("pending_expectations", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
